boss_dmg_sched: RTL and testbench
=================================

BOSS_DMG_SCHED -- requirements
Module: boss_dmg_sched

Interface
REQ-001 Parameter IFRAME_CYCLES, default 32, sets the invulnerability window length in clk cycles after each applied hit; legal range 1..255.
REQ-002 Parameter PEND_MAX, default 7, sets the saturation value of each per-source pending-hit counter, giving 3-bit counters.
REQ-003 clk  in  1  system clock; all state SHALL change on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 game_start  in  1  single-cycle restart pulse.
REQ-006 game_active  in  2  nonzero means the fight is running.
REQ-007 melee_hit  in  1  single-cycle hit pulse from the local melee source (src 0).
REQ-008 projectile_hit  in  1  single-cycle hit pulse from the local projectile source (src 1).
REQ-009 remote_hit  in  1  single-cycle hit pulse from the player-2 link (src 2).
REQ-010 boss_hp  in  7  current boss HP, fed back from the HP register.
REQ-011 dmg_strobe  out  1  single-cycle request to decrement boss HP by 1.
REQ-012 dmg_src  out  2  source of the granted hit (0 melee, 1 projectile, 2 remote); valid only when dmg_strobe=1.
REQ-013 iframe  out  1  high while the boss is invulnerable.
REQ-014 boss_defeated  out  1  high in the DEFEATED state.
REQ-015 pend_overflow  out  1  sticky flag, set when a hit is dropped.

Function
REQ-016 The block SHALL implement an FSM with the states IDLE, FIGHT, IFRAME and DEFEATED.
REQ-017 Per-source pending counter: a hit pulse increments it, a grant decrements it, and both in the same cycle leave it unchanged.
REQ-018 A hit pulse arriving when its counter equals PEND_MAX with no simultaneous grant SHALL be dropped and SHALL set pend_overflow.
REQ-019 IDLE -> FIGHT when game_active != 0.
REQ-020 In FIGHT, with boss_hp != 0 and any counter nonzero, the block SHALL grant exactly one source, round-robin starting after the last granted source, and SHALL take IFRAME.
REQ-021 On a grant, dmg_strobe SHALL be 1 for exactly one cycle and dmg_src SHALL hold the source.
REQ-022 Latency: a hit at edge n, in FIGHT with all counters at 0, SHALL produce dmg_strobe during cycle n+1 (registered output).
REQ-023 IFRAME SHALL last exactly IFRAME_CYCLES cycles, with iframe=1, then return to FIGHT.
REQ-024 Hits arriving in IFRAME SHALL queue in their counters and SHALL NOT strobe.
REQ-025 From FIGHT or IFRAME, boss_hp == 0 SHALL move to DEFEATED, clear all counters, and suppress dmg_strobe in that cycle.
REQ-026 In DEFEATED, boss_defeated=1 and hits SHALL be ignored.
REQ-027 From FIGHT or IFRAME, game_active == 0 SHALL move to IDLE and clear all counters.
REQ-028 game_start in any state SHALL clear the counters, pend_overflow and the IFRAME timer, and set the round-robin pointer so melee has top priority.
REQ-029 After game_start the next state SHALL be FIGHT if game_active != 0, otherwise IDLE.
REQ-030 game_start SHALL take priority over hits, grants and boss_hp==0 in the same cycle.
REQ-031 Simultaneous hits from several sources SHALL each be counted; none SHALL be lost below saturation.

Reset
REQ-032 rst SHALL force IDLE and clear all counters, the IFRAME timer and pend_overflow.
REQ-033 rst SHALL set the round-robin pointer so melee has top priority.
REQ-034 Reset output values SHALL be dmg_strobe=0, dmg_src=0, iframe=0, boss_defeated=0 and pend_overflow=0.
REQ-035 rst SHALL abort an IFRAME in progress, and rst SHALL take priority over game_start.

Structure
REQ-036 Package boss_pkg SHALL hold the state enum, the dmg_src_t enum, PEND_W=3, and defaults for IFRAME_CYCLES and PEND_MAX.
REQ-037 Sub-module boss_hit_queue SHALL implement one saturating pending counter with inc, dec and clr inputs and count, nonzero and overflow outputs; it SHALL be instantiated three times.
REQ-038 The round-robin arbiter and the FSM SHALL reside in boss_dmg_sched.

Verification
REQ-039 Scenario, single hit: game_active=1, single melee_hit -> dmg_strobe the next cycle with dmg_src=0, then iframe=1 for 32 cycles, then FIGHT.
REQ-040 Scenario, round-robin: melee, projectile and remote hit in the same cycle -> strobes ordered src 0, 1, 2, spaced 33 cycles apart, with all counters ending at 0.
REQ-041 Scenario, overflow: 9 remote_hit pulses during IFRAME -> pend_overflow=1 and exactly 7 subsequent remote strobes.
REQ-042 Scenario, defeat: boss_hp=0 while hits are pending -> DEFEATED with boss_defeated=1, no further strobes, and counters at 0.
REQ-043 Scenario, restart: game_start in the same cycle as a hit while in DEFEATED -> FIGHT, counters 0, pend_overflow 0, and no strobe in that cycle.
REQ-044 Scenario, mid-IFRAME reset: rst asserted during IFRAME -> all outputs equal their REQ-034 values the next cycle; a hit after rst is released is strobed only after game_active != 0.

Source files
------------

// File: rtl/boss_pkg.sv
// Shared types and defaults for the boss damage scheduler.
package boss_pkg;

    localparam int unsigned PEND_W            = 3;
    localparam int unsigned IFRAME_CYCLES_DEF = 32;
    localparam int unsigned PEND_MAX_DEF      = 7;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FIGHT    = 2'd1,
        ST_IFRAME   = 2'd2,
        ST_DEFEATED = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SRC_MELEE  = 2'd0,
        SRC_PROJ   = 2'd1,
        SRC_REMOTE = 2'd2
    } dmg_src_t;

    // Next source in round-robin order: melee -> projectile -> remote -> melee.
    function automatic dmg_src_t next_src(input dmg_src_t s);
        case (s)
            SRC_MELEE: return SRC_PROJ;
            SRC_PROJ:  return SRC_REMOTE;
            default:   return SRC_MELEE;
        endcase
    endfunction

endpackage

// File: rtl/boss_hit_queue.sv
// One saturating pending-hit counter. clr wins over inc/dec; an inc that
// would exceed PEND_MAX without a matching dec is dropped and flagged for
// that cycle on overflow.
module boss_hit_queue
    import boss_pkg::*;
#(
    parameter int unsigned PEND_MAX = PEND_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] count,
    output logic              nonzero,
    output logic              overflow
);

    localparam logic [PEND_W-1:0] MAX_C = PEND_W'(PEND_MAX);

    logic [PEND_W-1:0] count_q;
    logic [PEND_W-1:0] count_d;

    // Next count and drop detection.
    always_comb begin
        count_d  = count_q;
        overflow = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (inc && !dec) begin
            if (count_q == MAX_C) begin
                overflow = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (dec && !inc) begin
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign nonzero = (count_q != '0);

endmodule

// File: rtl/boss_dmg_sched.sv
// Boss damage scheduler: queues hits from three sources, grants one at a
// time round-robin, then holds the boss invulnerable for IFRAME_CYCLES.
module boss_dmg_sched
    import boss_pkg::*;
#(
    parameter int unsigned IFRAME_CYCLES = IFRAME_CYCLES_DEF,
    parameter int unsigned PEND_MAX      = PEND_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_start,
    input  logic [1:0] game_active,
    input  logic       melee_hit,
    input  logic       projectile_hit,
    input  logic       remote_hit,
    input  logic [6:0] boss_hp,
    output logic       dmg_strobe,
    output logic [1:0] dmg_src,
    output logic       iframe,
    output logic       boss_defeated,
    output logic       pend_overflow
);

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    dmg_src_t   last_q, last_d;
    logic       strobe_q, strobe_d;
    dmg_src_t   src_q, src_d;
    logic       iframe_q, iframe_d;
    logic       defeated_q, defeated_d;
    logic       ovf_q, ovf_d;

    logic [2:0]        hit_vec;
    logic [2:0]        q_inc;
    logic [2:0]        q_dec;
    logic [2:0]        q_nz;
    logic [2:0]        q_ovf;
    logic              q_clr;
    logic [2:0]        req;
    logic              fight_on;
    logic              grant_found;
    logic              grant_vld;
    dmg_src_t          grant_src;
    dmg_src_t          cand;
    logic [PEND_W-1:0] pend_cnt [3];
    logic              unused_pend_cnt;

    assign hit_vec  = {remote_hit, projectile_hit, melee_hit};
    assign fight_on = (state_q == ST_FIGHT) || (state_q == ST_IFRAME);

    // Queue controls: game_start and leaving the fight wipe the queues
    // (clr dominates any same-cycle hit); hits are ignored once defeated.
    always_comb begin
        q_clr = game_start || (fight_on && ((game_active == 2'd0) || (boss_hp == 7'd0)));
        q_inc = (!game_start && (state_q != ST_DEFEATED)) ? hit_vec : 3'b000;
        q_dec = 3'b000;
        if (grant_vld) begin
            q_dec[grant_src] = 1'b1;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_q
        boss_hit_queue #(
            .PEND_MAX(PEND_MAX)
        ) u_q (
            .clk     (clk),
            .rst     (rst),
            .clr     (q_clr),
            .inc     (q_inc[i]),
            .dec     (q_dec[i]),
            .count   (pend_cnt[i]),
            .nonzero (q_nz[i]),
            .overflow(q_ovf[i])
        );
    end

    // Counts are kept for observability only; grants use the nonzero flags.
    assign unused_pend_cnt = ^{pend_cnt[0], pend_cnt[1], pend_cnt[2]};

    // Round-robin arbiter: a same-cycle hit counts as a request so an idle
    // queue can be granted with one cycle of latency (inc+dec cancel).
    always_comb begin
        req         = q_nz | hit_vec;
        grant_found = 1'b0;
        grant_src   = SRC_MELEE;
        cand        = last_q;
        for (int unsigned k = 0; k < 3; k++) begin
            cand = next_src(cand);
            if (!grant_found && req[cand]) begin
                grant_found = 1'b1;
                grant_src   = cand;
            end
        end
        grant_vld = grant_found && (state_q == ST_FIGHT) && !game_start &&
                    (game_active != 2'd0) && (boss_hp != 7'd0);
    end

    // FSM next-state and registered-output values.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        last_d   = last_q;
        strobe_d = 1'b0;
        src_d    = src_q;
        ovf_d    = ovf_q | (|q_ovf);
        if (game_start) begin
            state_d = (game_active != 2'd0) ? ST_FIGHT : ST_IDLE;
            timer_d = '0;
            last_d  = SRC_REMOTE;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (game_active != 2'd0) begin
                        state_d = ST_FIGHT;
                    end
                end
                ST_FIGHT: begin
                    if (game_active == 2'd0) begin
                        state_d = ST_IDLE;
                    end else if (boss_hp == 7'd0) begin
                        state_d = ST_DEFEATED;
                    end else if (grant_vld) begin
                        state_d  = ST_IFRAME;
                        timer_d  = 8'(IFRAME_CYCLES - 1);
                        last_d   = grant_src;
                        strobe_d = 1'b1;
                        src_d    = grant_src;
                    end
                end
                ST_IFRAME: begin
                    if (game_active == 2'd0) begin
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end else if (boss_hp == 7'd0) begin
                        state_d = ST_DEFEATED;
                        timer_d = '0;
                    end else if (timer_q == '0) begin
                        state_d = ST_FIGHT;
                    end else begin
                        timer_d = timer_q - 8'd1;
                    end
                end
                default: begin
                    state_d = ST_DEFEATED;
                end
            endcase
        end
        iframe_d   = (state_d == ST_IFRAME);
        defeated_d = (state_d == ST_DEFEATED);
    end

    // FSM state, timer, arbiter pointer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            last_q     <= SRC_REMOTE;
            strobe_q   <= 1'b0;
            src_q      <= SRC_MELEE;
            iframe_q   <= 1'b0;
            defeated_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            last_q     <= last_d;
            strobe_q   <= strobe_d;
            src_q      <= src_d;
            iframe_q   <= iframe_d;
            defeated_q <= defeated_d;
            ovf_q      <= ovf_d;
        end
    end

    assign dmg_strobe    = strobe_q;
    assign dmg_src       = src_q;
    assign iframe        = iframe_q;
    assign boss_defeated = defeated_q;
    assign pend_overflow = ovf_q;

endmodule

// File: tb/tb_boss_dmg_sched.sv
// Directed bench for boss_dmg_sched: per-cycle vector table plus
// multi-cycle sequences for IFRAME length, round-robin, overflow,
// defeat and mid-IFRAME reset.
module tb_boss_dmg_sched;

    logic       clk;
    logic       rst;
    logic       game_start;
    logic [1:0] game_active;
    logic       melee_hit;
    logic       projectile_hit;
    logic       remote_hit;
    logic [6:0] boss_hp;
    logic       dmg_strobe;
    logic [1:0] dmg_src;
    logic       iframe;
    logic       boss_defeated;
    logic       pend_overflow;

    int unsigned n_pass;
    int unsigned n_total;

    boss_dmg_sched #(
        .IFRAME_CYCLES(32),
        .PEND_MAX(7)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .game_start    (game_start),
        .game_active   (game_active),
        .melee_hit     (melee_hit),
        .projectile_hit(projectile_hit),
        .remote_hit    (remote_hit),
        .boss_hp       (boss_hp),
        .dmg_strobe    (dmg_strobe),
        .dmg_src       (dmg_src),
        .iframe        (iframe),
        .boss_defeated (boss_defeated),
        .pend_overflow (pend_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       gs;
        logic [1:0] ga;
        logic [2:0] hits;     // {remote, projectile, melee}
        logic [6:0] hp;
        logic       e_str;
        logic [1:0] e_src;
        logic       e_if;
        logic       e_def;
        logic       e_ovf;
        logic [8:0] e_cnt;    // {remote, projectile, melee} counts
    } vec_t;

    vec_t vecs [14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [8:0] cnt_vec();
        return {dut.pend_cnt[2], dut.pend_cnt[1], dut.pend_cnt[0]};
    endfunction

    task automatic do_reset();
        rst            = 1'b1;
        game_start     = 1'b0;
        game_active    = 2'd0;
        melee_hit      = 1'b0;
        projectile_hit = 1'b0;
        remote_hit     = 1'b0;
        boss_hp        = 7'd100;
        tick();
        rst = 1'b0;
    endtask

    task automatic start_fight();
        do_reset();
        game_active = 2'd1;
        tick();
    endtask

    initial begin
        int unsigned n_if;
        int unsigned n_str;
        int unsigned n_rem;
        int unsigned s_cyc [4];
        int unsigned s_src [4];

        n_pass  = 0;
        n_total = 0;

        //            rst gs ga hits    hp    str src if def ovf cnt
        vecs[0]  = '{1'b1, 1'b0, 2'd0, 3'b000, 7'd100, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 9'o000};
        vecs[1]  = '{1'b0, 1'b0, 2'd0, 3'b000, 7'd100, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 9'o000};
        vecs[2]  = '{1'b0, 1'b0, 2'd1, 3'b000, 7'd100, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 9'o000};
        vecs[3]  = '{1'b0, 1'b0, 2'd1, 3'b001, 7'd100, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 9'o000};
        vecs[4]  = '{1'b0, 1'b0, 2'd1, 3'b000, 7'd100, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 9'o000};
        vecs[5]  = '{1'b0, 1'b0, 2'd1, 3'b010, 7'd100, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 9'o010};
        vecs[6]  = '{1'b0, 1'b0, 2'd1, 3'b000, 7'd0,   1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 9'o000};
        vecs[7]  = '{1'b0, 1'b0, 2'd1, 3'b111, 7'd0,   1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 9'o000};
        vecs[8]  = '{1'b0, 1'b1, 2'd1, 3'b111, 7'd100, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 9'o000};
        vecs[9]  = '{1'b0, 1'b0, 2'd1, 3'b000, 7'd100, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 9'o000};
        vecs[10] = '{1'b0, 1'b0, 2'd0, 3'b000, 7'd100, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 9'o000};
        vecs[11] = '{1'b1, 1'b1, 2'd1, 3'b000, 7'd100, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 9'o000};
        vecs[12] = '{1'b0, 1'b0, 2'd1, 3'b001, 7'd100, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 9'o001};
        vecs[13] = '{1'b0, 1'b0, 2'd1, 3'b000, 7'd100, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 9'o000};

        do_reset();

        // Per-cycle vector table.
        for (int unsigned i = 0; i < 14; i++) begin
            rst         = vecs[i].rst;
            game_start  = vecs[i].gs;
            game_active = vecs[i].ga;
            {remote_hit, projectile_hit, melee_hit} = vecs[i].hits;
            boss_hp     = vecs[i].hp;
            tick();
            check($sformatf("row%0d_strobe", i), dmg_strobe, vecs[i].e_str);
            check($sformatf("row%0d_src", i), dmg_src, vecs[i].e_src);
            check($sformatf("row%0d_iframe", i), iframe, vecs[i].e_if);
            check($sformatf("row%0d_defeated", i), boss_defeated, vecs[i].e_def);
            check($sformatf("row%0d_overflow", i), pend_overflow, vecs[i].e_ovf);
            check($sformatf("row%0d_counts", i), cnt_vec(), vecs[i].e_cnt);
        end
        rst = 1'b0;
        game_start = 1'b0;
        {remote_hit, projectile_hit, melee_hit} = 3'b000;

        // Single hit: next-cycle strobe, 32-cycle IFRAME, then back to FIGHT.
        start_fight();
        melee_hit = 1'b1;
        tick();
        melee_hit = 1'b0;
        check("single_strobe", dmg_strobe, 1);
        check("single_src", dmg_src, 0);
        check("single_iframe", iframe, 1);
        n_if  = 1;
        n_str = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (iframe) n_if++;
            if (dmg_strobe) n_str++;
        end
        check("iframe_len", n_if, 32);
        check("iframe_no_strobe", n_str, 0);
        melee_hit = 1'b1;
        tick();
        melee_hit = 1'b0;
        check("after_iframe_strobe", dmg_strobe, 1);

        // Round-robin: three simultaneous hits, strobes 33 cycles apart.
        start_fight();
        {remote_hit, projectile_hit, melee_hit} = 3'b111;
        tick();
        {remote_hit, projectile_hit, melee_hit} = 3'b000;
        check("rr_first_strobe", dmg_strobe, 1);
        check("rr_first_src", dmg_src, 0);
        check("rr_counts_queued", cnt_vec(), 9'o110);
        n_str = 0;
        for (int unsigned c = 1; c <= 100; c++) begin
            tick();
            if (dmg_strobe) begin
                if (n_str < 4) begin
                    s_cyc[n_str] = c;
                    s_src[n_str] = dmg_src;
                end
                n_str++;
            end
        end
        check("rr_strobe_count", n_str, 2);
        if (n_str >= 2) begin
            check("rr_second_cycle", s_cyc[0], 33);
            check("rr_second_src", s_src[0], 1);
            check("rr_third_cycle", s_cyc[1], 66);
            check("rr_third_src", s_src[1], 2);
        end
        check("rr_counts_empty", cnt_vec(), 0);

        // Overflow: 9 remote hits during IFRAME saturate at 7.
        start_fight();
        melee_hit = 1'b1;
        tick();
        melee_hit = 1'b0;
        remote_hit = 1'b1;
        for (int p = 1; p <= 9; p++) begin
            tick();
            if (p == 7) begin
                check("ovf_at7_flag", pend_overflow, 0);
                check("ovf_at7_count", dut.pend_cnt[2], 7);
            end
            if (p == 8) begin
                check("ovf_at8_flag", pend_overflow, 1);
            end
        end
        remote_hit = 1'b0;
        check("ovf_sat_count", dut.pend_cnt[2], 7);
        n_str = 0;
        n_rem = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (dmg_strobe) begin
                n_str++;
                if (dmg_src == 2'd2) n_rem++;
            end
        end
        check("ovf_remote_strobes", n_rem, 7);
        check("ovf_total_strobes", n_str, 7);
        check("ovf_sticky", pend_overflow, 1);
        check("ovf_counts_empty", cnt_vec(), 0);

        // Defeat while hits are pending.
        start_fight();
        melee_hit = 1'b1;
        tick();
        melee_hit = 1'b0;
        {remote_hit, projectile_hit} = 2'b11;
        tick();
        {remote_hit, projectile_hit} = 2'b00;
        check("def_pending", cnt_vec(), 9'o110);
        boss_hp = 7'd0;
        tick();
        check("def_flag", boss_defeated, 1);
        check("def_iframe", iframe, 0);
        check("def_counts", cnt_vec(), 0);
        boss_hp = 7'd100;
        melee_hit = 1'b1;
        n_str = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            melee_hit = 1'b0;
            if (dmg_strobe) n_str++;
        end
        check("def_no_strobes", n_str, 0);
        check("def_flag_held", boss_defeated, 1);
        check("def_counts_held", cnt_vec(), 0);

        // Reset in the middle of IFRAME, then a hit queued in IDLE.
        start_fight();
        projectile_hit = 1'b1;
        tick();
        projectile_hit = 1'b0;
        check("rstif_src_before", dmg_src, 1);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstif_strobe", dmg_strobe, 0);
        check("rstif_src", dmg_src, 0);
        check("rstif_iframe", iframe, 0);
        check("rstif_defeated", boss_defeated, 0);
        check("rstif_overflow", pend_overflow, 0);
        game_active = 2'd0;
        projectile_hit = 1'b1;
        tick();
        projectile_hit = 1'b0;
        n_str = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (dmg_strobe) n_str++;
        end
        check("rstif_idle_no_strobe", n_str, 0);
        check("rstif_idle_queued", dut.pend_cnt[1], 1);
        game_active = 2'd2;
        tick();
        check("rstif_enter_fight", dmg_strobe, 0);
        tick();
        check("rstif_strobe_late", dmg_strobe, 1);
        check("rstif_src_late", dmg_src, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
